// File: rtl/ser_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Latency: start bit begins one cycle after the accept edge. Backpressure: s_ready is high only while idle.
module ser_tx #(
    parameter int DATA_W     = 32,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              tx_d,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d_n;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d_n;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (cyc_q == CYC_LAST);

        case (state_q)
            IDLE: begin
                if (s_valid && rdy_q) begin
                    state_d = START;
                    cyc_d   = '0;
                    bit_d   = '0;
                    shift_d = s_data;
                    par_d   = ^s_data;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so the line changes on the same edge as the state.
        tx_d_n = 1'b1;
        case (state_d)
            START:   tx_d_n = 1'b0;
            DATA:    tx_d_n = shift_d[0];
            PARITY:  tx_d_n = par_d;
            default: tx_d_n = 1'b1;
        endcase
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cyc_d == CYC_LAST);
    end

    assign s_ready = rdy_q;
    assign tx_d    = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
